// File: rtl/shift_unit_iter_pkg.sv
// ---------------------------------------------------------------------------
// shift_unit_iter_pkg
// Shared definitions for the iterative shift unit: the two-bit operation
// encodings seen on op_i and the three-state controller enum.
// Optional feature macro: SHIFT_UNIT_ITER_ROTATE_EN (enables OP_ROR as a
// right rotate; without it OP_ROR is treated as a left shift).
// ---------------------------------------------------------------------------
package shift_unit_iter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational single step of the iterative shifter: moves data_i
// by amt_i (0..STEP) bits in the direction selected by op_i.
// Optional feature macro: SHIFT_UNIT_ITER_ROTATE_EN (adds the rotate path).
// Ports:
//   data_i  WIDTH bits   value to shift
//   op_i    2 bits       operation (OP_SLL/OP_SRL/OP_SRA/OP_ROR)
//   amt_i   AW bits      bits to move this step, never above STEP
//   fill_i  1 bit        sign bit used to fill the MSBs for SRA
//   data_o  WIDTH bits   shifted value
// ---------------------------------------------------------------------------
module shift_step
  import shift_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [AW-1:0]    amt_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] signMask;

  // The top amt_i bits are set in signMask; OR-ing the fill bit into them
  // turns a logical right shift into an arithmetic one.
  always_comb begin
    signMask = ~({WIDTH{1'b1}} >> amt_i);
    case (op_i)
      OP_SRL:  data_o = data_i >> amt_i;
      OP_SRA:  data_o = (data_i >> amt_i) | (signMask & {WIDTH{fill_i}});
`ifdef SHIFT_UNIT_ITER_ROTATE_EN
      // With amt_i = 0 the left shift by WIDTH yields zero, so the value
      // passes through unchanged.
      OP_ROR:  data_o = (data_i >> amt_i) | (data_i << (WIDTH - int'(amt_i)));
`endif
      default: data_o = data_i << amt_i;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// ---------------------------------------------------------------------------
// shift_unit_iter
// Iterative shifter: a request is captured on start_i, then the operand is
// shifted by at most STEP bits per cycle until the requested amount has been
// consumed. The final value is presented on data_o together with a one-cycle
// done_o pulse. Intermediate values never reach data_o.
// Optional feature macro: SHIFT_UNIT_ITER_ROTATE_EN (op 11 = rotate right;
// otherwise op 11 behaves as SLL).
// Ports:
//   clk_i    1 bit        clock, rising edge
//   rst_i    1 bit        synchronous active-high reset
//   start_i  1 bit        new request, sampled in IDLE or DONE only
//   op_i     2 bits       00 SLL, 01 SRL, 10 SRA, 11 ROR/SLL
//   shamt_i  SW bits      shift amount, unsigned
//   data_i   WIDTH bits   operand
//   busy_o   1 bit        high while shifting
//   done_o   1 bit        one-cycle result-valid pulse
//   data_o   WIDTH bits   registered result
// ---------------------------------------------------------------------------
module shift_unit_iter
  import shift_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               op_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         data_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int AW = $clog2(STEP + 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [SW-1:0]    rem_q;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             done_q;

  logic [AW-1:0]    stepAmt;
  logic [WIDTH-1:0] acc_d;
  logic [SW-1:0]    rem_d;

  // Bits consumed this cycle: a full STEP while enough remain, otherwise
  // whatever is left so the last step lands exactly on the requested amount.
  always_comb begin
    if (rem_q >= SW'(STEP)) begin
      stepAmt = AW'(STEP);
    end else begin
      stepAmt = AW'(rem_q);
    end
    rem_d = rem_q - SW'(stepAmt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_shift_step (
    .data_i (acc_q),
    .op_i   (op_q),
    .amt_i  (stepAmt),
    .fill_i (fill_q),
    .data_o (acc_d)
  );

  // Controller and datapath registers. busy/done are registered alongside the
  // state so they decode it exactly without glitches. The SRA fill bit is
  // frozen at capture time so later steps never depend on the moving acc.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      fill_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q <= ST_DONE;
            data_q  <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (start_i) begin
            acc_q  <= data_i;
            rem_q  <= shamt_i;
            op_q   <= op_i;
            fill_q <= data_i[WIDTH-1];
            if (shamt_i == '0) begin
              state_q <= ST_DONE;
              data_q  <= data_i;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_iter
// Directed, table-driven bench for shift_unit_iter (WIDTH=32, STEP=4) plus
// hand-written sequences for back-to-back starts, starts during SHIFT and
// reset during SHIFT. Honours SHIFT_UNIT_ITER_ROTATE_EN for the op 11 vector.
// ---------------------------------------------------------------------------
module tb_shift_unit_iter;
  import shift_unit_iter_pkg::*;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SW    = $clog2(WIDTH);

  typedef struct {
    logic [1:0]       op;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] expData;
    int               expLat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] dataIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;

  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] prevResult;
  int               gotLat;
  int               gotBusy;
  vec_t             vecs [9];

  shift_unit_iter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .shamt_i (shamt),
    .data_i  (dataIn),
    .busy_o  (busy),
    .done_o  (done),
    .data_o  (dataOut)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scramble request inputs; they must be ignored outside the sampling edge.
  task automatic scrambleInputs();
    op     = 2'($urandom_range(3));
    shamt  = SW'($urandom_range(31));
    dataIn = $urandom;
  endtask

  // Issue one request, then follow it to done_o. While shifting, data_o must
  // still show the previous result.
  task automatic applyStimulus(input logic [1:0] o, input logic [SW-1:0] sh,
                               input logic [WIDTH-1:0] d, input string name);
    @(negedge clk);
    op = o; shamt = sh; dataIn = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scrambleInputs();
    gotLat  = 1;
    gotBusy = 0;
    while (!done && gotLat < 100) begin
      if (busy) gotBusy++;
      checkOutput({name, " hold"}, dataOut, prevResult);
      @(posedge clk); #1;
      gotLat++;
    end
  endtask

  initial begin
    vecs[0] = '{OP_SLL, 5'd2,  32'h0000_0001, 32'h0000_0004, 2};
    vecs[1] = '{OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9};
    vecs[2] = '{OP_SRL, 5'd28, 32'hF000_0000, 32'h0000_000F, 8};
    vecs[3] = '{OP_SLL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    vecs[4] = '{OP_SRA, 5'd4,  32'h8000_00F0, 32'hF800_000F, 2};
    vecs[5] = '{OP_SRL, 5'd5,  32'hFFFF_FFFF, 32'h07FF_FFFF, 3};
    vecs[6] = '{OP_SLL, 5'd30, 32'h0000_0003, 32'hC000_0000, 9};
    vecs[7] = '{OP_SRA, 5'd16, 32'h7FFF_FFFF, 32'h0000_7FFF, 5};
`ifdef SHIFT_UNIT_ITER_ROTATE_EN
    vecs[8] = '{OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 2};
`else
    vecs[8] = '{OP_ROR, 5'd1,  32'h0000_0001, 32'h0000_0002, 2};
`endif

    rst = 1'b1; start = 1'b0; op = '0; shamt = '0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset data_o", dataOut, 32'h0);
    checkOutput("reset busy_o", 32'(busy), 32'h0);
    checkOutput("reset done_o", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prevResult = '0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].shamt, vecs[i].data, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d latency", i), 32'(gotLat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(gotBusy), 32'(vecs[i].expLat - 1));
      checkOutput($sformatf("vec%0d data", i), dataOut, vecs[i].expData);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done pulse", i), 32'(done), 32'h0);
      checkOutput($sformatf("vec%0d data held", i), dataOut, vecs[i].expData);
      prevResult = vecs[i].expData;
    end

    // Back-to-back: start stays high through SHIFT and DONE.
    @(negedge clk);
    op = OP_SLL; shamt = 5'd4; dataIn = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b first busy", 32'(busy), 32'h1);
    op = OP_SRL; shamt = 5'd8; dataIn = 32'h0000_0100;
    @(posedge clk); #1;
    checkOutput("b2b first done", 32'(done), 32'h1);
    checkOutput("b2b first data", dataOut, 32'h0000_0010);
    @(posedge clk); #1;
    checkOutput("b2b second busy", 32'(busy), 32'h1);
    checkOutput("b2b no done", 32'(done), 32'h0);
    start = 1'b0;
    scrambleInputs();
    @(posedge clk); #1;
    checkOutput("b2b hold", dataOut, 32'h0000_0010);
    @(posedge clk); #1;
    checkOutput("b2b second done", 32'(done), 32'h1);
    checkOutput("b2b second data", dataOut, 32'h0000_0001);
    @(posedge clk); #1;

    // Extra start while shifting must not disturb the operation.
    @(negedge clk);
    op = OP_SRL; shamt = 5'd28; dataIn = 32'hF000_0000; start = 1'b1;
    @(posedge clk); #1;
    gotLat = 1;
    op = OP_SLL; shamt = 5'd0; dataIn = 32'h0000_FFFF;
    @(posedge clk); #1;
    gotLat++;
    @(posedge clk); #1;
    gotLat++;
    start = 1'b0;
    while (!done && gotLat < 100) begin
      @(posedge clk); #1;
      gotLat++;
    end
    checkOutput("ignore start latency", 32'(gotLat), 32'd8);
    checkOutput("ignore start data", dataOut, 32'h0000_000F);
    @(posedge clk); #1;

    // Reset mid-SHIFT, with start asserted too: reset wins, nothing completes.
    @(negedge clk);
    op = OP_SRA; shamt = 5'd31; dataIn = 32'h8000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid reset data_o", dataOut, 32'h0);
    checkOutput("mid reset busy_o", 32'(busy), 32'h0);
    checkOutput("mid reset done_o", 32'(done), 32'h0);
    @(posedge clk); #1;
    checkOutput("reset over start busy", 32'(busy), 32'h0);
    rst = 1'b0; start = 1'b0;
    gotBusy = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) gotBusy++;
    end
    checkOutput("no done after reset", 32'(gotBusy), 32'h0);
    checkOutput("data after reset", dataOut, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_iter.md
SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 32, SHALL set the data width; legal values are powers of two, 8 or more.
REQ-003 Parameter STEP, default 4, SHALL set the maximum bits shifted per cycle; legal values are powers of two from 1 to WIDTH/2.
REQ-004 Port clk_i, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start_i, input, 1 bit: request a new shift; sampled only in IDLE or DONE.
REQ-007 Port op_i, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
REQ-008 Port shamt_i, input, $clog2(WIDTH) bits: shift amount, unsigned.
REQ-009 Port data_i, input, WIDTH bits: operand.
REQ-010 Port busy_o, output, 1 bit: high while in SHIFT.
REQ-011 Port done_o, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 Port data_o, output, WIDTH bits: registered result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 When start_i=1 in IDLE or DONE, the block SHALL capture op_i, shamt_i and data_i into internal registers (acc, rem, op) at that edge.
REQ-015 On a start with shamt_i=0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-016 Each cycle in SHIFT, the block SHALL shift acc by n=min(STEP,rem) according to op and decrement rem by n.
REQ-017 The transition SHIFT->DONE SHALL occur on the edge at which rem reaches 0.
REQ-018 Fill rules: SLL fills LSBs with 0; SRL fills MSBs with 0; SRA fills MSBs with acc[WIDTH-1] captured at start.
REQ-019 Latency SHALL be 1+ceil(shamt/STEP) cycles from the start-sampling edge to done_o=1.
REQ-020 data_o SHALL be loaded with the final acc on entry to DONE and SHALL hold that value until the next entry to DONE; intermediate values SHALL NOT appear on data_o.
REQ-021 Signal decodes: done_o=(state==DONE); busy_o=(state==SHIFT).
REQ-022 In DONE without start_i, the next state SHALL be IDLE.
REQ-023 In DONE with start_i, the block SHALL accept the new request back-to-back with no idle cycle.
REQ-024 start_i asserted while in SHIFT SHALL be ignored; there is no queueing and the operation in flight SHALL NOT be corrupted.
REQ-025 Input values (op_i, shamt_i, data_i) SHALL be don't-care outside the start-sampling edge.

Reset
REQ-026 rst_i=1 at a rising edge SHALL force state to IDLE and set data_o=0, done_o=0, busy_o=0, acc=0 and rem=0.
REQ-027 rst_i SHALL take priority over start_i.
REQ-028 A reset during SHIFT SHALL abort the operation with no done_o pulse.

Configuration
REQ-029 With macro SHIFT_UNIT_ITER_ROTATE_EN defined, op 11 SHALL perform a right rotate (ROR) with the same step and latency rules as the shifts.
REQ-030 Without SHIFT_UNIT_ITER_ROTATE_EN, op 11 SHALL behave exactly as SLL, and no rotate logic SHALL be synthesised.

Structure
REQ-031 Package shift_unit_iter_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR) and the state enum.
REQ-032 One combinational sub-module, shift_step, SHALL perform a single shift of up to STEP bits given op, amount and the fill bit.
REQ-033 The FSM, counters and registers SHALL live in shift_unit_iter.

Verification (WIDTH=32, STEP=4)
REQ-034 SLL, data 0x0000_0001, shamt 2 -> data_o=0x0000_0004; done_o 2 cycles after start; busy_o high for exactly 1 cycle.
REQ-035 SRA, data 0x8000_0000, shamt 31 -> data_o=0xFFFF_FFFF; latency 9.
REQ-036 SRL, data 0xF000_0000, shamt 28 -> data_o=0x0000_000F; latency 8.
REQ-037 shamt 0, data 0xDEAD_BEEF -> data_o=0xDEAD_BEEF; latency 1.
REQ-038 Back-to-back: start held high through DONE -> second result follows with no IDLE cycle. Extra start during SHIFT -> ignored.
REQ-039 Reset: rst_i pulsed mid-SHIFT -> data_o=0, no done_o pulse. Op 11, data 0x0000_0001, shamt 1 -> 0x8000_0000 with the macro defined; 0x0000_0002 without it.
